// File: rtl/dmem_pkg.sv
// Shared types and defaults for the stalling data-memory responder.
package dmem_pkg;

    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 3;
    // Wide enough to count up to the maximum legal latency of 15.
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_if.sv
// Pipeline-to-data-memory bus; the pipeline holds requests stable while stall_o is high.
interface dmem_if;

    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Address_i;
    logic [31:0] Write_data_i;
    logic [31:0] Read_data_o;
    logic        stall_o;
    logic        err_o;

    modport master (
        output MemRead_i, MemWrite_i, Address_i, Write_data_i,
        input  Read_data_o, stall_o, err_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, Address_i, Write_data_i,
        output Read_data_o, stall_o, err_o
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 32 bits wide; one-cycle registered read.
// Only the read-data register is reset, the storage keeps its contents.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // A write-enabled access leaves the last read value untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stalls the pipeline LATENCY cycles per access, then one DONE cycle.
// Backpressure via stall_o; requests must stay stable while it is high.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic   clk_i,
    input  logic   rst_i,
    dmem_if.slave  bus
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;
    logic             req;
    logic             stall;
    logic             complete;
    logic             malformed;
    logic             mem_en;
    logic             unused_addr_hi;

    assign req       = bus.MemRead_i || bus.MemWrite_i;
    assign malformed = (bus.MemRead_i && bus.MemWrite_i) || (bus.Address_i[1:0] != 2'b00);
    assign unused_addr_hi = ^bus.Address_i[31:IDX_W+2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    stall = 1'b1;
                    if (LATENCY == 1) begin
                        complete = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    complete = 1'b1;
                    state_d  = DONE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Inputs still carry the finished access here, so they are ignored.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= complete && malformed;
        end
    end

    // A reset landing on the completion edge aborts the access.
    assign mem_en = complete && !rst_i;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (mem_en),
        .we    (bus.MemWrite_i),
        .addr  (bus.Address_i[IDX_W+1:2]),
        .wdata (bus.Write_data_i),
        .rdata (bus.Read_data_o)
    );

    assign bus.stall_o = stall;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and random accesses checked against a word-array model of the memory.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 3;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rd;

    dmem_if dif ();

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; requests are held through DONE and dropped afterwards.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        int stalls;
        int idx;
        bit exp_err;
        @(negedge clk);
        dif.MemRead_i    = rd;
        dif.MemWrite_i   = wr;
        dif.Address_i    = addr;
        dif.Write_data_i = wdata;
        #1;
        stalls = 0;
        while (dif.stall_o === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 32'(stalls), 32'(LATENCY));
        idx = int'((addr / 4) % DEPTH);
        if (wr) ref_mem[idx] = wdata;
        else if (rd) exp_rd = ref_mem[idx];
        exp_err = (rd && wr) || (addr % 4 != 0);
        chk("done_err", 32'(dif.err_o), 32'(exp_err));
        chk("done_rdata", dif.Read_data_o, exp_rd);
        @(negedge clk);
        dif.MemRead_i  = 1'b0;
        dif.MemWrite_i = 1'b0;
        #1;
        chk("after_done_stall", 32'(dif.stall_o), 32'd0);
        chk("after_done_err", 32'(dif.err_o), 32'd0);
    endtask

    initial begin
        int stall_sum;
        bit rd;
        bit wr;

        rst              = 1'b1;
        dif.MemRead_i    = 1'b0;
        dif.MemWrite_i   = 1'b0;
        dif.Address_i    = '0;
        dif.Write_data_i = '0;
        exp_rd           = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rdata", dif.Read_data_o, 32'd0);
        chk("reset_err", 32'(dif.err_o), 32'd0);
        chk("reset_stall", 32'(dif.stall_o), 32'd0);
        rst = 1'b0;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        chk("rd_deadbeef", dif.Read_data_o, 32'hDEADBEEF);

        access(1'b1, 1'b1, 32'h20, 32'h12345678);
        chk("both_keeps_rdata", dif.Read_data_o, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        chk("both_wrote_mem8", dif.Read_data_o, 32'h12345678);

        access(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5);
        access(1'b1, 1'b0, 32'h13, 32'h0);
        chk("misaligned_rd", dif.Read_data_o, 32'hA5A5A5A5);

        access(1'b0, 1'b1, 32'h400, 32'h1);
        access(1'b1, 1'b0, 32'h0, 32'h0);
        chk("alias_rd", dif.Read_data_o, 32'h1);

        // Read held continuously: two accesses in 2*(LATENCY+1) cycles.
        @(negedge clk);
        dif.MemRead_i  = 1'b1;
        dif.MemWrite_i = 1'b0;
        dif.Address_i  = 32'h10;
        stall_sum = 0;
        for (int c = 0; c < 2 * (LATENCY + 1); c++) begin
            #1;
            if (dif.stall_o === 1'b1) stall_sum++;
            @(negedge clk);
        end
        dif.MemRead_i = 1'b0;
        #1;
        chk("b2b_stalls", 32'(stall_sum), 32'(2 * LATENCY));
        chk("b2b_rdata", dif.Read_data_o, 32'hA5A5A5A5);
        exp_rd = 32'hA5A5A5A5;

        // Reset on the last stall cycle of a write must abort it.
        access(1'b0, 1'b1, 32'h4, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        dif.MemWrite_i   = 1'b1;
        dif.Address_i    = 32'h4;
        dif.Write_data_i = 32'h55;
        @(negedge clk);
        @(negedge clk);
        rst            = 1'b1;
        dif.MemWrite_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_rd = '0;
        chk("abort_stall", 32'(dif.stall_o), 32'd0);
        chk("abort_rdata", dif.Read_data_o, 32'd0);
        chk("abort_err", 32'(dif.err_o), 32'd0);
        access(1'b1, 1'b0, 32'h4, 32'h0);
        chk("abort_no_write", dif.Read_data_o, 32'h0);

        for (int n = 0; n < 60; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            access(rd, wr, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
